// File: rtl/decoder_pkg.sv
// Purpose: shared decode types and scoreboard helpers for the decode/issue boundary.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package decoder_pkg;

    localparam int NUM_GPRS     = 32;
    localparam int REG_IDX_W    = 5;
    // Widest writeback-port count the match helper can handle.
    localparam int MAX_WB_PORTS = 8;

    typedef struct packed {
        logic                 undefined;
        logic                 is_link;
        logic                 is_branch;
        logic                 r_rs1;
        logic                 r_rs2;
        logic                 r_rs3;
        logic                 r_flags;
        logic                 w_rd;
        logic                 w_flags;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rs3;
        logic [REG_IDX_W-1:0] rd;
    } decoded_t;

    // Number of valid writeback ports whose destination equals idx.
    // Callers zero-extend their port vectors up to MAX_WB_PORTS.
    function automatic logic [3:0] wb_match_count(
        input logic [MAX_WB_PORTS-1:0]           vld,
        input logic [REG_IDX_W*MAX_WB_PORTS-1:0] rd,
        input logic [REG_IDX_W-1:0]              idx
    );
        logic [3:0] n;
        n = '0;
        for (int p = 0; p < MAX_WB_PORTS; p++) begin
            if (vld[p] && (rd[p*REG_IDX_W +: REG_IDX_W] == idx)) begin
                n = n + 4'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Purpose: saturating up/down in-flight counter for one scoreboard resource.
// Latency: count updates one cycle after inc/dec; underflow is combinational.
// Backpressure: none; the caller gates inc so the counter never exceeds MAX_COUNT.
module sb_counter #(
    parameter int MAX_COUNT = 3,
    parameter int CNT_W     = 2,
    parameter int DEC_W     = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             underflow
);

    localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

    logic [SUM_W-1:0] up;
    logic [SUM_W-1:0] dn;
    logic [SUM_W-1:0] diff;
    logic [CNT_W-1:0] nxt;

    assign up        = SUM_W'(count) + SUM_W'(inc);
    assign dn        = SUM_W'(dec);
    assign underflow = dn > up;
    assign diff      = up - dn;
    assign nonzero   = (count != '0);

    // Next count: retiring more than is outstanding pins at zero, growth saturates.
    always_comb begin
        nxt = count;
        if (underflow) begin
            nxt = '0;
        end else if (diff > SUM_W'(MAX_COUNT)) begin
            nxt = CNT_W'(MAX_COUNT);
        end else begin
            nxt = CNT_W'(diff);
        end
    end

    // Counter state; clr discards everything outstanding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            count <= nxt;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Purpose: multi-writeback GPR/flags scoreboard between decode and issue.
// Latency: dec_ready is combinational from current counts; busy/empty lag updates by one cycle.
// Backpressure: dec_ready drops on RAW, capacity, undefined-while-busy or flush.
module reg_scoreboard
    import decoder_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 3,
    parameter int WB_PORTS     = 2,
    parameter int BYPASS       = 1,
    parameter int R0_ZERO      = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          dec_valid,
    input  decoded_t                      dec,
    output logic                          dec_ready,
    input  logic [WB_PORTS-1:0]           wb_valid,
    input  logic [REG_IDX_W*WB_PORTS-1:0] wb_rd,
    input  logic [WB_PORTS-1:0]           wb_flags,
    input  logic                          flush,
    output logic [NUM_REGS-1:0]           busy,
    output logic                          flags_busy,
    output logic                          empty,
    output logic                          err_underflow
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int DEC_W = $clog2(WB_PORTS + 1);
    // Resource NUM_REGS is the flags counter; 0..NUM_REGS-1 are GPRs.
    localparam int FLG   = NUM_REGS;
    localparam int NRES  = NUM_REGS + 1;

    logic [CNT_W-1:0]    cnt [NRES];
    logic [DEC_W-1:0]    ret [NRES];
    logic [NRES-1:0]     inc;
    logic [NRES-1:0]     nz;
    logic [NRES-1:0]     under;
    logic [NUM_GPRS-1:0] raw_blk;
    logic [NUM_GPRS-1:0] cap_blk;
    logic                flags_raw;
    logic                flags_cap;
    logic                raw_haz;
    logic                cap_haz;
    logic                hazard;
    logic                fire;
    logic                alloc;
    logic                dec_unused;

    // Link/branch information is carried through rd/w_rd; the flags themselves are not needed here.
    assign dec_unused = ^{dec.is_link, dec.is_branch};

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam bit TRACK = !((R0_ZERO != 0) && (i == 0));
        logic [3:0] hits;
        assign hits   = wb_match_count(MAX_WB_PORTS'(wb_valid),
                                       (REG_IDX_W*MAX_WB_PORTS)'(wb_rd),
                                       REG_IDX_W'(i));
        assign ret[i] = TRACK ? DEC_W'(hits) : '0;
        assign inc[i] = TRACK && alloc && dec.w_rd && (dec.rd == REG_IDX_W'(i));

        sb_counter #(.MAX_COUNT(MAX_INFLIGHT), .CNT_W(CNT_W), .DEC_W(DEC_W)) u_cnt (
            .clk       (clk),
            .rstn      (rstn),
            .clr       (flush),
            .inc       (inc[i]),
            .dec       (ret[i]),
            .count     (cnt[i]),
            .nonzero   (nz[i]),
            .underflow (under[i])
        );
    end

    // Flags retire count ignores wb_valid: a port may retire flags without a GPR.
    assign ret[FLG] = DEC_W'($countones(wb_flags));
    assign inc[FLG] = alloc && dec.w_flags;

    sb_counter #(.MAX_COUNT(MAX_INFLIGHT), .CNT_W(CNT_W), .DEC_W(DEC_W)) u_flags_cnt (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (flush),
        .inc       (inc[FLG]),
        .dec       (ret[FLG]),
        .count     (cnt[FLG]),
        .nonzero   (nz[FLG]),
        .underflow (under[FLG])
    );

    // Per-register block vectors padded to the full index space so rs/rd can index directly.
    // A last outstanding write retiring this cycle releases readers; retirements free capacity.
    for (genvar i = 0; i < NUM_GPRS; i++) begin : g_blk
        if (i < NUM_REGS) begin : g_on
            assign raw_blk[i] = nz[i] &&
                                !((BYPASS != 0) && (cnt[i] == CNT_W'(1)) && (ret[i] != '0));
            assign cap_blk[i] = (cnt[i] == CNT_W'(MAX_INFLIGHT)) &&
                                !((BYPASS != 0) && (ret[i] != '0));
        end else begin : g_off
            assign raw_blk[i] = 1'b0;
            assign cap_blk[i] = 1'b0;
        end
    end

    assign flags_raw = nz[FLG] &&
                       !((BYPASS != 0) && (cnt[FLG] == CNT_W'(1)) && (ret[FLG] != '0));
    assign flags_cap = (cnt[FLG] == CNT_W'(MAX_INFLIGHT)) &&
                       !((BYPASS != 0) && (ret[FLG] != '0));

    assign raw_haz = (dec.r_rs1   && raw_blk[dec.rs1]) ||
                     (dec.r_rs2   && raw_blk[dec.rs2]) ||
                     (dec.r_rs3   && raw_blk[dec.rs3]) ||
                     (dec.r_flags && flags_raw);
    assign cap_haz = (dec.w_rd    && cap_blk[dec.rd]) ||
                     (dec.w_flags && flags_cap);

    // An undefined instruction waits for a fully drained pipe so its exception is precise.
    assign hazard    = dec.undefined ? !empty : (raw_haz || cap_haz);
    assign dec_ready = !flush && !hazard;
    assign fire      = dec_valid && dec_ready;
    assign alloc     = fire && !dec.undefined;

    assign busy       = nz[NUM_REGS-1:0];
    assign flags_busy = nz[FLG];
    assign empty      = ~|nz;

    // Sticky underflow flag; retirements during a flush are discarded and cannot raise it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_underflow <= 1'b0;
        end else if (!flush && (|under)) begin
            err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Purpose: directed self-checking bench for reg_scoreboard (default config plus a no-bypass copy).
// Latency: checks dec_ready mid-cycle and registered outputs 1 time unit after the edge.
// Backpressure: stimulus holds an instruction until dec_ready is expected to rise.
module tb_reg_scoreboard;
    import decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        dec_valid;
    decoded_t    dec;
    logic        dec_ready;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;
    logic [1:0]  wb_flags;
    logic        flush;
    logic [31:0] busy;
    logic        flags_busy;
    logic        empty;
    logic        err_underflow;

    logic        dec_valid_nb;
    decoded_t    dec_nb;
    logic        dec_ready_nb;
    logic [1:0]  wb_flags_nb;
    logic [31:0] busy_nb;
    logic        flags_busy_nb;
    logic        empty_nb;
    logic        err_underflow_nb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk           (clk),
        .rstn          (rstn),
        .dec_valid     (dec_valid),
        .dec           (dec),
        .dec_ready     (dec_ready),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_flags      (wb_flags),
        .flush         (flush),
        .busy          (busy),
        .flags_busy    (flags_busy),
        .empty         (empty),
        .err_underflow (err_underflow)
    );

    reg_scoreboard #(.BYPASS(0)) dut_nb (
        .clk           (clk),
        .rstn          (rstn),
        .dec_valid     (dec_valid_nb),
        .dec           (dec_nb),
        .dec_ready     (dec_ready_nb),
        .wb_valid      (2'b00),
        .wb_rd         (10'd0),
        .wb_flags      (wb_flags_nb),
        .flush         (1'b0),
        .busy          (busy_nb),
        .flags_busy    (flags_busy_nb),
        .empty         (empty_nb),
        .err_underflow (err_underflow_nb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid    = 1'b0;
        dec          = '0;
        wb_valid     = '0;
        wb_rd        = '0;
        wb_flags     = '0;
        flush        = 1'b0;
        dec_valid_nb = 1'b0;
        dec_nb       = '0;
        wb_flags_nb  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rstn = 1'b0;
        idle();
        #12;
        chk("rst_busy",       64'(busy),          64'd0);
        chk("rst_flags_busy", 64'(flags_busy),    64'd0);
        chk("rst_empty",      64'(empty),         64'd1);
        chk("rst_err",        64'(err_underflow), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // No-bypass copy: flags reader waits until the cycle after the retirement.
        dec_nb = '0; dec_nb.w_flags = 1'b1; dec_valid_nb = 1'b1;
        #1 chk("nb_alloc_rdy", 64'(dec_ready_nb), 64'd1);
        tick();
        chk("nb_flags_busy", 64'(flags_busy_nb), 64'd1);
        dec_nb = '0; dec_nb.r_flags = 1'b1;
        #1 chk("nb_raw_stall", 64'(dec_ready_nb), 64'd0);
        tick();
        wb_flags_nb = 2'b01;
        #1 chk("nb_no_bypass", 64'(dec_ready_nb), 64'd0);
        tick();
        wb_flags_nb = 2'b00;
        #1 chk("nb_rdy_after", 64'(dec_ready_nb), 64'd1);
        chk("nb_flags_clear", 64'(flags_busy_nb), 64'd0);
        tick();
        idle();

        // Allocate r5, RAW stall, bypass release on wb port 0.
        dec = '0; dec.w_rd = 1'b1; dec.rd = 5'd5; dec_valid = 1'b1;
        #1 chk("t1_alloc_rdy", 64'(dec_ready), 64'd1);
        tick();
        chk("t1_busy5", 64'(busy), 64'h20);
        dec = '0; dec.r_rs1 = 1'b1; dec.rs1 = 5'd5;
        #1 chk("t1_raw_stall", 64'(dec_ready), 64'd0);
        tick();
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd5};
        #1 chk("t1_bypass_rdy", 64'(dec_ready), 64'd1);
        tick();
        idle();
        chk("t1_busy_clear", 64'(busy),  64'd0);
        chk("t1_empty",      64'(empty), 64'd1);

        // r0 is never tracked.
        dec = '0; dec.w_rd = 1'b1; dec.rd = 5'd0; dec_valid = 1'b1;
        tick();
        idle();
        chk("r0_empty", 64'(empty), 64'd1);

        // Capacity on r7, then a fourth write released by a retirement on port 1.
        dec = '0; dec.w_rd = 1'b1; dec.rd = 5'd7; dec_valid = 1'b1;
        tick(); tick(); tick();
        chk("t2_busy7", 64'(busy), 64'h80);
        #1 chk("t2_cap_stall", 64'(dec_ready), 64'd0);
        wb_valid = 2'b10; wb_rd = {5'd7, 5'd0};
        #1 chk("t2_cap_release", 64'(dec_ready), 64'd1);
        tick();
        idle();
        wb_valid = 2'b11; wb_rd = {5'd7, 5'd7};
        tick();
        chk("t2_still_busy", 64'(busy), 64'h80);
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd7};
        tick();
        idle();
        chk("t2_drained", 64'(busy),          64'd0);
        chk("t2_no_err",  64'(err_underflow), 64'd0);

        // Flags RAW with bypass: released in the retiring cycle.
        dec = '0; dec.w_flags = 1'b1; dec_valid = 1'b1;
        tick();
        chk("t4_flags_busy", 64'(flags_busy), 64'd1);
        dec = '0; dec.r_flags = 1'b1;
        #1 chk("t4_raw_stall", 64'(dec_ready), 64'd0);
        tick();
        #1 chk("t4_raw_hold", 64'(dec_ready), 64'd0);
        wb_flags = 2'b01;
        #1 chk("t4_bypass_rdy", 64'(dec_ready), 64'd1);
        tick();
        idle();
        chk("t4_flags_clear", 64'(flags_busy), 64'd0);

        // Undefined instruction waits for empty and allocates nothing.
        dec = '0; dec.w_rd = 1'b1; dec.rd = 5'd3; dec_valid = 1'b1;
        tick();
        chk("t5_busy3", 64'(busy), 64'h8);
        dec = '0; dec.undefined = 1'b1; dec.w_rd = 1'b1; dec.rd = 5'd10;
        #1 chk("t5_undef_stall", 64'(dec_ready), 64'd0);
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd3};
        #1 chk("t5_undef_no_bypass", 64'(dec_ready), 64'd0);
        tick();
        wb_valid = 2'b00; wb_rd = '0;
        chk("t5_empty", 64'(empty), 64'd1);
        #1 chk("t5_undef_rdy", 64'(dec_ready), 64'd1);
        tick();
        idle();
        chk("t5_no_alloc", 64'(busy),  64'd0);
        chk("t5_still_empty", 64'(empty), 64'd1);

        // Flush discards counts and same-cycle fire/wb.
        dec = '0; dec.w_rd = 1'b1; dec.rd = 5'd4; dec.w_flags = 1'b1; dec_valid = 1'b1;
        tick();
        dec.w_flags = 1'b0;
        tick();
        idle();
        chk("t6_not_empty", 64'(empty), 64'd0);
        flush = 1'b1;
        dec = '0; dec.w_rd = 1'b1; dec.rd = 5'd12; dec_valid = 1'b1;
        wb_valid = 2'b11; wb_rd = {5'd20, 5'd4};
        #1 chk("t6_flush_rdy", 64'(dec_ready), 64'd0);
        tick();
        idle();
        chk("t6_empty",      64'(empty),         64'd1);
        chk("t6_busy",       64'(busy),          64'd0);
        chk("t6_flags_busy", 64'(flags_busy),    64'd0);
        chk("t6_no_err",     64'(err_underflow), 64'd0);

        // Double retire on r9, r0 writeback is harmless, extra retire is sticky error.
        dec = '0; dec.w_rd = 1'b1; dec.rd = 5'd9; dec_valid = 1'b1;
        tick(); tick();
        idle();
        chk("t3_busy9", 64'(busy), 64'h200);
        wb_valid = 2'b11; wb_rd = {5'd9, 5'd9};
        tick();
        idle();
        chk("t3_busy_clear", 64'(busy),          64'd0);
        chk("t3_no_err",     64'(err_underflow), 64'd0);
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd0};
        tick();
        idle();
        chk("t3_r0_no_err", 64'(err_underflow), 64'd0);
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd9};
        tick();
        idle();
        chk("t3_underflow", 64'(err_underflow), 64'd1);
        tick();
        chk("t3_sticky", 64'(err_underflow), 64'd1);

        // Asynchronous reset mid-cycle.
        dec = '0; dec.w_rd = 1'b1; dec.rd = 5'd6; dec.w_flags = 1'b1; dec_valid = 1'b1;
        tick();
        idle();
        chk("ar_busy6", 64'(busy), 64'h40);
        #2 rstn = 1'b0;
        #1;
        chk("ar_busy",       64'(busy),          64'd0);
        chk("ar_flags_busy", 64'(flags_busy),    64'd0);
        chk("ar_empty",      64'(empty),         64'd1);
        chk("ar_err",        64'(err_underflow), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
